// File: rtl/wb_bist_master_if.sv
// Wishbone classic bus bundle between the BIST master and the memory under test.
interface wb_bist_master_if #(
   parameter int APP_AW = 26,
   parameter int dw     = 32
);
   logic              wb_cyc_o;
   logic              wb_stb_o;
   logic              wb_we_o;
   logic [APP_AW-1:0] wb_addr_o;
   logic [dw-1:0]     wb_dat_o;
   logic [dw/8-1:0]   wb_sel_o;
   logic [2:0]        wb_cti_o;
   logic              wb_ack_i;
   logic [dw-1:0]     wb_dat_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
      input  wb_ack_i, wb_dat_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
      output wb_ack_i, wb_dat_i
   );
endinterface

// File: rtl/wb_bist_master.sv
// Wishbone classic memory BIST master: writes a pattern over cfg_len words, then reads back and compares.
// Optional ack-timeout watchdog is built when WB_BIST_TIMEOUT_EN is defined.
module wb_bist_master #(
   parameter int APP_AW = 26,
   parameter int dw     = 32,
   parameter int TMO_W  = 8
) (
   input  logic              wb_clk_i,
   input  logic              reset_n,
   input  logic              start,
   input  logic [APP_AW-1:0] cfg_base_addr,
   input  logic [15:0]       cfg_len,
   input  logic [1:0]        cfg_pattern,
   input  logic [31:0]       cfg_seed,
   wb_bist_master_if.master  wb,
   output logic              busy,
   output logic              done,
   output logic              pass_fail,
   output logic [15:0]       err_count,
   output logic [APP_AW-1:0] first_err_addr
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_REQ = 3'd1,
      WR_GAP = 3'd2,
      RD_REQ = 3'd3,
      RD_GAP = 3'd4,
      FIN    = 3'd5
   } state_t;

   localparam logic [APP_AW-1:0] ADDR_STEP  = APP_AW'(3'd4);
   localparam logic [APP_AW-1:0] ALIGN_MASK = ~APP_AW'(2'd3);

   // Galois form of x^32+x^22+x^2+x+1, shifting right
   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
   endfunction

   function automatic logic [dw-1:0] pat_word(input logic [1:0] p, input logic [APP_AW-1:0] a,
                                              input logic odd, input logic [31:0] l);
      logic [31:0] w;
      case (p)
         2'b00:   w = 32'(a);
         2'b01:   w = odd ? 32'hAAAA_5555 : 32'h5555_AAAA;
         2'b10:   w = 32'hFFFF_FFFF;
         default: w = l;
      endcase
      return dw'(w);
   endfunction

   state_t            state_q, state_d;
   logic [APP_AW-1:0] base_q, base_d, addr_q, addr_d, ferr_q, ferr_d;
   logic [15:0]       len_q, len_d, idx_q, idx_d, err_q, err_d;
   logic [1:0]        pat_q, pat_d;
   logic [31:0]       seed_q, seed_d, lfsr_q, lfsr_d;
   logic [dw-1:0]     dat_q, dat_d;
   logic [dw/8-1:0]   sel_q, sel_d;
   logic              cyc_q, cyc_d, we_q, we_d;
   logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;

   logic [APP_AW-1:0] addr_n_s, base_s;
   logic [15:0]       idx_n_s;
   logic [31:0]       lfsr_n_s, seed_s;
   logic              last_s;
`ifdef WB_BIST_TIMEOUT_EN
   logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

   // Next-state, datapath and bus-control decode
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      addr_d   = addr_q;
      ferr_d   = ferr_q;
      len_d    = len_q;
      idx_d    = idx_q;
      err_d    = err_q;
      pat_d    = pat_q;
      seed_d   = seed_q;
      lfsr_d   = lfsr_q;
      dat_d    = dat_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      base_s   = cfg_base_addr & ALIGN_MASK;
      seed_s   = (cfg_seed == 32'h0) ? 32'h1 : cfg_seed;
      addr_n_s = addr_q + ADDR_STEP;
      idx_n_s  = idx_q + 16'd1;
      lfsr_n_s = lfsr_step(lfsr_q);
      last_s   = (idx_n_s == len_q);
`ifdef WB_BIST_TIMEOUT_EN
      tmo_d    = {TMO_W{1'b0}};
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               base_d = base_s;
               addr_d = base_s;
               len_d  = cfg_len;
               pat_d  = cfg_pattern;
               seed_d = seed_s;
               lfsr_d = seed_s;
               idx_d  = 16'd0;
               dat_d  = pat_word(cfg_pattern, base_s, 1'b0, seed_s);
               err_d  = 16'd0;
               ferr_d = {APP_AW{1'b0}};
               done_d = 1'b0;
               if (cfg_len == 16'd0) begin
                  state_d = FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end else begin
                  state_d = WR_REQ;
                  busy_d  = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WR_REQ: begin
            if (wb.wb_ack_i) begin
               if (last_s) begin
                  state_d = RD_GAP;
                  addr_d  = base_q;
                  idx_d   = 16'd0;
                  lfsr_d  = seed_q;
                  dat_d   = pat_word(pat_q, base_q, 1'b0, seed_q);
               end else begin
                  state_d = WR_GAP;
                  addr_d  = addr_n_s;
                  idx_d   = idx_n_s;
                  lfsr_d  = lfsr_n_s;
                  dat_d   = pat_word(pat_q, addr_n_s, idx_n_s[0], lfsr_n_s);
               end
            end else begin
               state_d = WR_REQ;
            end
         end
         WR_GAP: state_d = WR_REQ;
         RD_REQ: begin
            if (wb.wb_ack_i) begin
               // dat_q still holds the expected word for the address on the bus
               if (wb.wb_dat_i != dat_q) begin
                  err_d  = (err_q != 16'hFFFF) ? (err_q + 16'd1) : err_q;
                  ferr_d = (err_q == 16'd0) ? addr_q : ferr_q;
               end else begin
                  err_d  = err_q;
               end
               if (last_s) begin
                  state_d = FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 16'd0);
               end else begin
                  state_d = RD_GAP;
                  addr_d  = addr_n_s;
                  idx_d   = idx_n_s;
                  lfsr_d  = lfsr_n_s;
                  dat_d   = pat_word(pat_q, addr_n_s, idx_n_s[0], lfsr_n_s);
               end
            end else begin
               state_d = RD_REQ;
            end
         end
         RD_GAP:  state_d = RD_REQ;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef WB_BIST_TIMEOUT_EN
      if (((state_q == WR_REQ) || (state_q == RD_REQ)) && !wb.wb_ack_i) begin
         tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
         if (tmo_d == {TMO_W{1'b1}}) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            err_d   = 16'hFFFF;
            ferr_d  = addr_q;
            tmo_d   = {TMO_W{1'b0}};
         end else begin
            state_d = state_q;
         end
      end else begin
         tmo_d = {TMO_W{1'b0}};
      end
`endif
      cyc_d = (state_d == WR_REQ) || (state_d == RD_REQ);
      we_d  = (state_d == WR_REQ);
      sel_d = cyc_d ? {(dw/8){1'b1}} : {(dw/8){1'b0}};
   end

   // State and output registers
   always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         base_q  <= {APP_AW{1'b0}};
         addr_q  <= {APP_AW{1'b0}};
         ferr_q  <= {APP_AW{1'b0}};
         len_q   <= 16'd0;
         idx_q   <= 16'd0;
         err_q   <= 16'd0;
         pat_q   <= 2'b00;
         seed_q  <= 32'h0;
         lfsr_q  <= 32'h0;
         dat_q   <= {dw{1'b0}};
         sel_q   <= {(dw/8){1'b0}};
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
`ifdef WB_BIST_TIMEOUT_EN
         tmo_q   <= {TMO_W{1'b0}};
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         ferr_q  <= ferr_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         pat_q   <= pat_d;
         seed_q  <= seed_d;
         lfsr_q  <= lfsr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
`ifdef WB_BIST_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign wb.wb_cyc_o    = cyc_q;
   assign wb.wb_stb_o    = cyc_q;
   assign wb.wb_we_o     = we_q;
   assign wb.wb_addr_o   = addr_q;
   assign wb.wb_dat_o    = dat_q;
   assign wb.wb_sel_o    = sel_q;
   assign wb.wb_cti_o    = 3'b000;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass_fail      = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;
endmodule

// File: tb/tb_wb_bist_master.sv
// Bench for wb_bist_master: table of BIST runs against a latency-configurable memory slave,
// plus hand sequences for held results, restart clearing, mid-access reset and timeout.
module tb_wb_bist_master;
   localparam int AW  = 26;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, start, busy, done, pass_fail;
   logic [AW-1:0] cfg_base_addr, first_err_addr;
   logic [15:0]   cfg_len, err_count;
   logic [1:0]    cfg_pattern;
   logic [31:0]   cfg_seed;

   wb_bist_master_if #(.APP_AW(AW), .dw(DW)) bus ();

   wb_bist_master #(.APP_AW(AW), .dw(DW), .TMO_W(TMO)) dut (
      .wb_clk_i(clk), .reset_n(reset_n), .start(start),
      .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len), .cfg_pattern(cfg_pattern),
      .cfg_seed(cfg_seed), .wb(bus), .busy(busy), .done(done), .pass_fail(pass_fail),
      .err_count(err_count), .first_err_addr(first_err_addr)
   );

   // Memory slave: ack after lat stalled cycles, stray acks while cyc is low, corruptible reads
   int            lat, wait_cnt;
   logic          no_ack, stray_ack, ack_s;
   logic [7:0]    corrupt_mask;
   logic [AW-1:0] cur_base, off_s;
   logic [31:0]   rd_data, mem [0:255];

   always_comb begin
      off_s = bus.wb_addr_o - cur_base;
      if (bus.wb_cyc_o) ack_s = bus.wb_stb_o && !no_ack && (wait_cnt == lat);
      else ack_s = stray_ack;
      rd_data = mem[bus.wb_addr_o[9:2]];
      if ((off_s[AW-1:2] < 8) && corrupt_mask[off_s[4:2]]) rd_data = rd_data ^ 32'h0000_0100;
   end
   assign bus.wb_ack_i = ack_s;
   assign bus.wb_dat_i = rd_data;

   always @(posedge clk) begin
      if (bus.wb_cyc_o && bus.wb_stb_o && !ack_s) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   // Bus monitor: logs completed transfers, stb run lengths and idle gaps inside a test
   int            nwr = 0, nrd = 0, nacc = 0, ngap = 0, run_len = 0;
   logic [AW-1:0] wr_addr [0:4095], rd_addr [0:4095];
   logic [31:0]   wr_data [0:4095];
   int            acc_len [0:4095];

   always @(negedge clk) begin
      if (bus.wb_cyc_o && bus.wb_stb_o) begin
         if (ack_s) begin
            acc_len[nacc] <= run_len + 1;
            nacc          <= nacc + 1;
            run_len       <= 0;
            if (bus.wb_we_o) begin
               wr_addr[nwr]                <= bus.wb_addr_o;
               wr_data[nwr]                <= bus.wb_dat_o;
               mem[bus.wb_addr_o[9:2]]     <= bus.wb_dat_o;
               nwr                         <= nwr + 1;
            end else begin
               rd_addr[nrd] <= bus.wb_addr_o;
               nrd          <= nrd + 1;
            end
         end else begin
            run_len <= run_len + 1;
         end
      end else begin
         run_len <= 0;
         if (busy) ngap <= ngap + 1;
      end
   end

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [1:0] p, input logic [AW-1:0] a,
                                            input int n, input logic [31:0] seed);
      logic [31:0] l;
      l = (seed == 32'h0) ? 32'h1 : seed;
      for (int j = 0; j < n; j++) l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
      case (p)
         2'b00:   return 32'(a);
         2'b01:   return (n % 2 == 1) ? 32'hAAAA_5555 : 32'h5555_AAAA;
         2'b10:   return 32'hFFFF_FFFF;
         default: return l;
      endcase
   endfunction

   task automatic pulse_start(input logic [AW-1:0] b, input logic [15:0] l, input logic [1:0] p,
                              input logic [31:0] s);
      cfg_base_addr = b; cfg_len = l; cfg_pattern = p; cfg_seed = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc, output int stb_cyc);
      cyc = 1; stb_cyc = 0;
      while (!done && cyc < budget) begin
         if (bus.wb_stb_o) stb_cyc++;
         @(negedge clk);
         cyc++;
      end
   endtask

   typedef struct {
      logic [AW-1:0] base;
      logic [15:0]   len;
      logic [1:0]    pat;
      logic [31:0]   seed;
      int            lat;
      logic [7:0]    cmask;
      int            restart_at;
      logic [15:0]   exp_err;
      logic [AW-1:0] exp_first;
      logic          exp_pass;
      int            exp_cycles;
   } vec_t;

   vec_t          vt [7];
   vec_t          v;
   int            w0, r0, a0, g0, cyc, stb_cyc;
   logic [AW-1:0] exp_a;

   initial begin
      vt[0] = '{26'h0000100, 16'd4, 2'b00, 32'h0,    0, 8'h00, 0, 16'd0, 26'h0,       1'b1, 16};
      vt[1] = '{26'h0000200, 16'd8, 2'b11, 32'h0,    0, 8'h00, 0, 16'd0, 26'h0,       1'b1, 32};
      vt[2] = '{26'h0000300, 16'd4, 2'b01, 32'h1234, 0, 8'h04, 0, 16'd1, 26'h0000308, 1'b0, 16};
      vt[3] = '{26'h0000040, 16'd0, 2'b00, 32'h0,    0, 8'h00, 0, 16'd0, 26'h0,       1'b1, 1};
      vt[4] = '{26'h0000403, 16'd3, 2'b10, 32'h0,    1, 8'h06, 0, 16'd2, 26'h0000404, 1'b0, 18};
      vt[5] = '{26'h3FFFFF8, 16'd4, 2'b00, 32'h0,    0, 8'h00, 0, 16'd0, 26'h0,       1'b1, 16};
      vt[6] = '{26'h0000500, 16'd2, 2'b01, 32'h0,    3, 8'h00, 5, 16'd0, 26'h0,       1'b1, 20};

      reset_n = 1'b0; start = 1'b0; cfg_base_addr = '0; cfg_len = '0; cfg_pattern = '0; cfg_seed = '0;
      lat = 0; no_ack = 1'b0; stray_ack = 1'b0; corrupt_mask = 8'h00; cur_base = '0;
      repeat (3) @(negedge clk);
      chk("rst_cyc", bus.wb_cyc_o, 0);
      chk("rst_stb", bus.wb_stb_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass_fail, 0);
      chk("rst_err", err_count, 0);
      reset_n = 1'b1;
      stray_ack = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         v = vt[i];
         lat = v.lat; corrupt_mask = v.cmask; cur_base = v.base & ~26'h3;
         w0 = nwr; r0 = nrd; a0 = nacc; g0 = ngap;
         pulse_start(v.base, v.len, v.pat, v.seed);
         chk($sformatf("v%0d_busy_start", i), busy, (v.len != 16'd0));
         cyc = 1;
         while (!done && cyc < 200) begin
            if (v.restart_at != 0 && cyc == v.restart_at) begin
               start = 1'b1; cfg_len = 16'd0; cfg_base_addr = 26'h0; cfg_pattern = 2'b10;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
         start = 1'b0;
         chk($sformatf("v%0d_done", i), done, 1);
         chk($sformatf("v%0d_cycles", i), cyc, v.exp_cycles);
         chk($sformatf("v%0d_busy_end", i), busy, 0);
         chk($sformatf("v%0d_pass", i), pass_fail, v.exp_pass);
         chk($sformatf("v%0d_err", i), err_count, v.exp_err);
         chk($sformatf("v%0d_first", i), first_err_addr, v.exp_first);
         chk($sformatf("v%0d_nwr", i), nwr - w0, v.len);
         chk($sformatf("v%0d_nrd", i), nrd - r0, v.len);
         chk($sformatf("v%0d_gaps", i), ngap - g0, (v.len == 16'd0) ? 0 : 2 * v.len - 1);
         for (int k = 0; k < int'(v.len); k++) begin
            exp_a = cur_base + AW'(4 * k);
            chk($sformatf("v%0d_wr_addr%0d", i, k), wr_addr[w0 + k], exp_a);
            chk($sformatf("v%0d_wr_data%0d", i, k), wr_data[w0 + k], exp_word(v.pat, exp_a, k, v.seed));
            chk($sformatf("v%0d_rd_addr%0d", i, k), rd_addr[r0 + k], exp_a);
         end
         for (int k = 0; k < nacc - a0; k++)
            chk($sformatf("v%0d_stb_len%0d", i, k), acc_len[a0 + k], v.lat + 1);
         repeat (2) @(negedge clk);
      end

      // Failing run: results held while idle, then cleared by the next accepted start
      lat = 0; corrupt_mask = 8'h04; cur_base = 26'h300;
      pulse_start(26'h300, 16'd4, 2'b01, 32'h0);
      wait_done(200, cyc, stb_cyc);
      repeat (5) @(negedge clk);
      chk("hold_done", done, 1);
      chk("hold_err", err_count, 1);
      chk("hold_first", first_err_addr, 26'h308);
      chk("hold_pass", pass_fail, 0);
      corrupt_mask = 8'h00; cur_base = 26'h600;
      pulse_start(26'h600, 16'd2, 2'b10, 32'h0);
      chk("restart_done_clr", done, 0);
      chk("restart_err_clr", err_count, 0);
      chk("restart_first_clr", first_err_addr, 0);
      wait_done(200, cyc, stb_cyc);
      chk("restart_pass", pass_fail, 1);
      repeat (2) @(negedge clk);

      // Reset asserted in the middle of a stalled access
      lat = 3; cur_base = 26'h700;
      pulse_start(26'h700, 16'd2, 2'b00, 32'h0);
      @(negedge clk);
      chk("mid_cyc_before", bus.wb_cyc_o, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_cyc", bus.wb_cyc_o, 0);
      chk("mid_rst_stb", bus.wb_stb_o, 0);
      chk("mid_rst_we", bus.wb_we_o, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_addr", bus.wb_addr_o, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_cyc", bus.wb_cyc_o, 0);

`ifdef WB_BIST_TIMEOUT_EN
      // Slave never acks: watchdog ends the test with a saturated error count
      no_ack = 1'b1; cur_base = 26'h800;
      pulse_start(26'h800, 16'd2, 2'b00, 32'h0);
      wait_done(2000, cyc, stb_cyc);
      chk("tmo_done", done, 1);
      chk("tmo_stb_cycles", stb_cyc, (1 << TMO) - 1);
      chk("tmo_err", err_count, 16'hFFFF);
      chk("tmo_pass", pass_fail, 0);
      chk("tmo_first", first_err_addr, 26'h800);
      no_ack = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
